ccp_l2_req_arbiter: RTL
=======================

Name: ccp_l2_req_arbiter

Overview:
- Shares the single L2 request port between NUM_SRC L1.5 private caches. Sources are owners 0..NUM_SRC-1.
- The L2 request port has two channels:
  - msg1: requests (LOAD_REQ, STORE_REQ, WB_REQ).
  - msg3: responses (FWDACK, MEM_ACK).
- Each source offers one msg1 and one msg3 message. The arbiter picks one and presents it to the L2 for exactly one cycle, then waits for the L2 to finish before it grants again.
- msg3 has strict priority over msg1 so that forward-acks can never be blocked behind new requests (deadlock avoidance). Within each channel, sources are served round-robin.

Parameters:
- NUM_SRC, 4, number of requesting caches (power of 2, at least 2).
- OWNER_BITS, 2, log2(NUM_SRC); width of the source field.
- MSG_WIDTH, 8, width of the message-type field. Type 0 means NOP.
- DATA_WIDTH, 64, width of the data field.
- TAG_WIDTH, 8, width of the tag field.
- TIMEOUT, 255, number of WAIT cycles before an aborted transaction is flagged.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req1_valid  in  NUM_SRC  per-source msg1 request pending.
- req1_type  in  NUM_SRC*MSG_WIDTH  flattened; source i occupies bits [i*MSG_WIDTH +: MSG_WIDTH].
- req1_data  in  NUM_SRC*DATA_WIDTH  flattened, same packing.
- req1_tag  in  NUM_SRC*TAG_WIDTH  flattened, same packing.
- req1_ready  out  NUM_SRC  one-hot pulse: source's msg1 accepted this cycle.
- req3_valid, req3_type, req3_data, req3_tag, req3_ready: same as req1_*, for msg3.
- l2_ack  in  1  single-cycle pulse: L2 finished the current message.
- msg1_type  out  MSG_WIDTH  to L2, registered.
- msg1_data  out  DATA_WIDTH  to L2, registered.
- msg1_tag  out  TAG_WIDTH  to L2, registered.
- msg1_source  out  OWNER_BITS  to L2, registered.
- msg3_type, msg3_data, msg3_tag, msg3_source: same as msg1_*, for msg3.
- busy  out  1  high whenever state != IDLE.
- err_timeout  out  1  sticky; cleared only by reset.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; both round-robin pointers rr1=rr3=0; timeout counter=0.
  - All msg*_* outputs, req*_ready, busy and err_timeout are 0.
- State IDLE:
  - If any req3_valid: grant the first valid source found by searching upward from rr3 with wrap. In the same cycle assert req3_ready[g] combinationally and load msg3_* from source g, with msg3_source=g. Set rr3=(g+1) mod NUM_SRC. Next state ISSUE.
  - Else if any req1_valid: the same, using the msg1 signals and rr1.
  - Else stay in IDLE.
- State ISSUE (exactly 1 cycle):
  - The registered message is visible on its channel; the other channel shows NOP (all fields 0).
  - If l2_ack=1, go to IDLE; otherwise go to WAIT.
- State WAIT:
  - All msg*_* outputs are 0. The counter increments every cycle.
  - On l2_ack, go to IDLE and clear the counter.
  - If the counter reaches TIMEOUT without l2_ack: set err_timeout, clear the counter, go to IDLE.
  - An l2_ack arriving in IDLE is ignored.
- Grant rate: at most one grant every 2 cycles; with l2_ack asserted in the ISSUE cycle, one grant per IDLE→ISSUE pair.
- req*_ready is asserted only in IDLE and is never high in more than one bit or on both channels at once.
- A source with both req3_valid and req1_valid asserted gets its msg3 served first; its msg1 waits for a later IDLE cycle.
- Requesters hold valid and payload stable until their ready pulse; the arbiter does not check this.
- Round-robin pointers only advance on a grant in their own channel, and wrap from NUM_SRC-1 to 0.
- Mid-transaction reset drops the message without any ack; the arbiter returns to the reset values.
- A TIMEOUT-aborted transaction is not retried.

Test Plan:
- Reset, then req1_valid=4'b0001 with type=1, tag=8'h12 → cycle 0: req1_ready=4'b0001. Next cycle: msg1_type=1, msg1_tag=8'h12, msg1_source=0, busy=1. l2_ack 3 cycles later → IDLE, outputs 0.
- req1_valid=4'b1111 held, l2_ack issued during every ISSUE cycle → grants to sources 0,1,2,3,0 in that order, one every 2 cycles.
- req1_valid=4'b0110 and req3_valid=4'b1000 in the same cycle → source 3 granted on msg3 first (msg3_source=3, msg1 shows NOP), then msg1 granted to source 1.
- Grant, then no l2_ack for TIMEOUT=255 cycles → err_timeout=1 at the 255th WAIT cycle, state returns to IDLE, new grants still occur, err_timeout stays 1.
- Assert rst=0 asynchronously during WAIT → all outputs 0 immediately; after release the next grant starts searching at source 0.
- l2_ack pulse while in IDLE with no requests → no state change, no ready pulse.

Source files
------------

// File: rtl/ccp_l2_req_arbiter.sv
// rtl/ccp_l2_req_arbiter.sv - shares one L2 request port between NUM_SRC caches, msg3 over msg1, round-robin per channel
module ccp_l2_req_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int OWNER_BITS = 2,
    parameter int MSG_WIDTH  = 8,
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SRC-1:0]              req1_valid,
    input  logic [NUM_SRC*MSG_WIDTH-1:0]    req1_type,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   req1_data,
    input  logic [NUM_SRC*TAG_WIDTH-1:0]    req1_tag,
    output logic [NUM_SRC-1:0]              req1_ready,
    input  logic [NUM_SRC-1:0]              req3_valid,
    input  logic [NUM_SRC*MSG_WIDTH-1:0]    req3_type,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   req3_data,
    input  logic [NUM_SRC*TAG_WIDTH-1:0]    req3_tag,
    output logic [NUM_SRC-1:0]              req3_ready,
    input  logic                            l2_ack,
    output logic [MSG_WIDTH-1:0]            msg1_type,
    output logic [DATA_WIDTH-1:0]           msg1_data,
    output logic [TAG_WIDTH-1:0]            msg1_tag,
    output logic [OWNER_BITS-1:0]           msg1_source,
    output logic [MSG_WIDTH-1:0]            msg3_type,
    output logic [DATA_WIDTH-1:0]           msg3_data,
    output logic [TAG_WIDTH-1:0]            msg3_tag,
    output logic [OWNER_BITS-1:0]           msg3_source,
    output logic                            busy,
    output logic                            err_timeout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t                state;
    logic [OWNER_BITS-1:0] rr1, rr3;
    logic [CW-1:0]         cnt;
    logic                  any1, any3;
    logic [OWNER_BITS-1:0] g1, g3;
    logic                  grant1, grant3;

    // Search upward from each pointer; OWNER_BITS-wide addition gives the wrap for free.
    always_comb begin
        logic [OWNER_BITS-1:0] idx1, idx3;
        any1 = 1'b0;
        any3 = 1'b0;
        g1   = '0;
        g3   = '0;
        idx1 = '0;
        idx3 = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx1 = rr1 + OWNER_BITS'(i);
            idx3 = rr3 + OWNER_BITS'(i);
            if (!any1 && req1_valid[idx1]) begin
                any1 = 1'b1;
                g1   = idx1;
            end
            if (!any3 && req3_valid[idx3]) begin
                any3 = 1'b1;
                g3   = idx3;
            end
        end
    end

    // Ready is gated by rst so it is already low while reset is asserted.
    assign grant3     = rst && (state == IDLE) && any3;
    assign grant1     = rst && (state == IDLE) && !any3 && any1;
    assign req3_ready = grant3 ? (NUM_SRC'(1) << g3) : '0;
    assign req1_ready = grant1 ? (NUM_SRC'(1) << g1) : '0;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rr1         <= '0;
            rr3         <= '0;
            cnt         <= '0;
            err_timeout <= 1'b0;
            msg1_type   <= '0;
            msg1_data   <= '0;
            msg1_tag    <= '0;
            msg1_source <= '0;
            msg3_type   <= '0;
            msg3_data   <= '0;
            msg3_tag    <= '0;
            msg3_source <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant3) begin
                        msg3_type   <= req3_type[g3*MSG_WIDTH +: MSG_WIDTH];
                        msg3_data   <= req3_data[g3*DATA_WIDTH +: DATA_WIDTH];
                        msg3_tag    <= req3_tag[g3*TAG_WIDTH +: TAG_WIDTH];
                        msg3_source <= g3;
                        rr3         <= g3 + 1'b1;
                        state       <= ISSUE;
                    end else if (grant1) begin
                        msg1_type   <= req1_type[g1*MSG_WIDTH +: MSG_WIDTH];
                        msg1_data   <= req1_data[g1*DATA_WIDTH +: DATA_WIDTH];
                        msg1_tag    <= req1_tag[g1*TAG_WIDTH +: TAG_WIDTH];
                        msg1_source <= g1;
                        rr1         <= g1 + 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    msg1_type   <= '0;
                    msg1_data   <= '0;
                    msg1_tag    <= '0;
                    msg1_source <= '0;
                    msg3_type   <= '0;
                    msg3_data   <= '0;
                    msg3_tag    <= '0;
                    msg3_source <= '0;
                    cnt         <= '0;
                    state       <= l2_ack ? IDLE : WAIT;
                end
                WAIT: begin
                    if (l2_ack) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        // Aborted transaction is dropped, not retried.
                        err_timeout <= 1'b1;
                        cnt         <= '0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
